// File: rtl/fpdiv_operand_stage_if.sv
// Operand-stage handshake bundle.
// Upstream side : in_valid / in_ready / in_dividend / in_divisor
// Downstream    : out_valid / out_ready / out_dividend / out_divisor,
//                 out_special / out_special_result / out_invalid / out_divzero
// master = the environment (producer of operands, consumer of the head entry)
// slave  = the operand stage itself
interface fpdiv_operand_stage_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_dividend;
    logic [31:0] in_divisor;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_dividend;
    logic [31:0] out_divisor;
    logic        out_special;
    logic [31:0] out_special_result;
    logic        out_invalid;
    logic        out_divzero;

    modport master (
        output in_valid, in_dividend, in_divisor, out_ready,
        input  in_ready, out_valid, out_dividend, out_divisor,
               out_special, out_special_result, out_invalid, out_divzero
    );

    modport slave (
        input  in_valid, in_dividend, in_divisor, out_ready,
        output in_ready, out_valid, out_dividend, out_divisor,
               out_special, out_special_result, out_invalid, out_divzero
    );
endinterface

// File: rtl/fpdiv_operand_stage.sv
// FP divider operand stage: a DEPTH-entry FIFO of IEEE-754 single operand
// pairs. Denormals are flushed to signed zero and each pair is classified
// (NaN / invalid / divide-by-zero / trivial zero or inf) as it is pushed, so
// the divider only sees the precomputed class bits alongside the head entry.
// Ports:
//   clk      - rising-edge clock
//   reset_n  - asynchronous active-low reset (empties the FIFO)
//   flush    - synchronous clear; beats a same-cycle push or pop
//   bus      - slave side of fpdiv_operand_stage_if (in_* push, out_* head)
module fpdiv_operand_stage #(
    parameter int unsigned DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 flush,
    fpdiv_operand_stage_if.slave bus
);
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);
    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    logic [31:0] r_dvd_mem  [DEPTH];
    logic [31:0] r_dvs_mem  [DEPTH];
    logic [31:0] r_res_mem  [DEPTH];
    logic        r_spec_mem [DEPTH];
    logic        r_inv_mem  [DEPTH];
    logic        r_dz_mem   [DEPTH];

    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;

    logic w_full;
    logic w_empty;
    logic w_push;
    logic w_pop;

    logic [31:0] w_dvd;
    logic [31:0] w_dvs;
    logic        w_sign;
    logic        w_a_zero, w_a_inf, w_a_nan;
    logic        w_b_zero, w_b_inf, w_b_nan;
    logic        w_spec;
    logic [31:0] w_res;
    logic        w_inv;
    logic        w_dz;

    assign w_full  = (r_count == FULL_COUNT);
    assign w_empty = (r_count == '0);
    // Push is gated only by full, so a pop in the same cycle does not free a slot.
    assign w_push  = bus.in_valid && !w_full;
    assign w_pop   = !w_empty && bus.out_ready;

    assign bus.in_ready = !w_full;

    // Denormal flush: exponent 0 keeps only the sign.
    always_comb begin
        w_dvd = bus.in_dividend;
        w_dvs = bus.in_divisor;
        if (bus.in_dividend[30:23] == 8'h00) begin
            w_dvd = {bus.in_dividend[31], 31'b0};
        end
        if (bus.in_divisor[30:23] == 8'h00) begin
            w_dvs = {bus.in_divisor[31], 31'b0};
        end
    end

    assign w_sign   = w_dvd[31] ^ w_dvs[31];
    assign w_a_zero = (w_dvd[30:23] == 8'h00);
    assign w_b_zero = (w_dvs[30:23] == 8'h00);
    assign w_a_inf  = (w_dvd[30:23] == 8'hFF) && (w_dvd[22:0] == '0);
    assign w_b_inf  = (w_dvs[30:23] == 8'hFF) && (w_dvs[22:0] == '0);
    assign w_a_nan  = (w_dvd[30:23] == 8'hFF) && (w_dvd[22:0] != '0);
    assign w_b_nan  = (w_dvs[30:23] == 8'hFF) && (w_dvs[22:0] != '0);

    // Priority chain; inf/0 resolves as inf/finite (no divzero) because the
    // dividend-inf test precedes the divisor-zero test.
    always_comb begin
        w_spec = 1'b0;
        w_res  = '0;
        w_inv  = 1'b0;
        w_dz   = 1'b0;
        if (w_a_nan || w_b_nan) begin
            w_spec = 1'b1;
            w_res  = QNAN;
            w_inv  = 1'b1;
        end else if ((w_a_inf && w_b_inf) || (w_a_zero && w_b_zero)) begin
            w_spec = 1'b1;
            w_res  = QNAN;
            w_inv  = 1'b1;
        end else if (w_a_inf) begin
            w_spec = 1'b1;
            w_res  = {w_sign, 8'hFF, 23'b0};
        end else if (w_b_zero) begin
            w_spec = 1'b1;
            w_res  = {w_sign, 8'hFF, 23'b0};
            w_dz   = 1'b1;
        end else if (w_a_zero || w_b_inf) begin
            w_spec = 1'b1;
            w_res  = {w_sign, 31'b0};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: entries are only visible through r_count.
    always_ff @(posedge clk) begin
        if (w_push && !flush) begin
            r_dvd_mem[r_wr_ptr]  <= w_dvd;
            r_dvs_mem[r_wr_ptr]  <= w_dvs;
            r_res_mem[r_wr_ptr]  <= w_res;
            r_spec_mem[r_wr_ptr] <= w_spec;
            r_inv_mem[r_wr_ptr]  <= w_inv;
            r_dz_mem[r_wr_ptr]   <= w_dz;
        end
    end

    always_comb begin
        bus.out_valid          = 1'b0;
        bus.out_dividend       = '0;
        bus.out_divisor        = '0;
        bus.out_special        = 1'b0;
        bus.out_special_result = '0;
        bus.out_invalid        = 1'b0;
        bus.out_divzero        = 1'b0;
        if (!w_empty) begin
            bus.out_valid          = 1'b1;
            bus.out_dividend       = r_dvd_mem[r_rd_ptr];
            bus.out_divisor        = r_dvs_mem[r_rd_ptr];
            bus.out_special        = r_spec_mem[r_rd_ptr];
            bus.out_special_result = r_res_mem[r_rd_ptr];
            bus.out_invalid        = r_inv_mem[r_rd_ptr];
            bus.out_divzero        = r_dz_mem[r_rd_ptr];
        end
    end
endmodule
